cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Memory-side responder for the cache control interface: accepts instruction-cache and data-cache requests and arbitrates them onto a single RAM port.
- Returns per-requester wait/load, so the caches see the same handshake whether they are caches or pass-through wiring.
- Sits between the caches block and the RAM model, one instance per core.
- Sequential: grant FSM, starvation counter, timeout counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- TIMEOUT, 64, maximum cycles a grant may wait for RAM ACCESS before abort.
- ISTARVE, 4, consecutive data grants allowed while an instruction request is pending.
- BAD_WORD, 32'hBAD1BAD1, load value returned on error or timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write word.
- iwait  out  1  low for exactly the completion cycle of an instruction read.
- dwait  out  1  low for exactly the completion cycle of a data access.
- iload  out  DATA_W  instruction read data, valid when iwait low.
- dload  out  DATA_W  data read data, valid when dwait low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values (async, RST high):
  - state=IDLE, counters=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0.
- States: IDLE, DGRANT, IGRANT.
- Arbitration in IDLE:
  - Data wins (DGRANT) if dREN|dWEN is asserted, unless starve_cnt==ISTARVE and iREN is asserted; in that case go to IGRANT.
  - Otherwise, iREN -> IGRANT.
  - Otherwise stay in IDLE.
  - Decision registers at the clock edge; RAM strobes go out the cycle after the request is first seen (1-cycle arbitration latency).
- starve_cnt:
  - Increments on each DGRANT entry while iREN is high.
  - Clears on IGRANT entry, or when iREN is low.
  - Saturates at ISTARVE.
- DGRANT:
  - ramaddr=daddr and ramstore=dstore.
  - If dWEN is set, ramWEN=1 and ramREN=0 (write wins over a simultaneous read); else ramREN=dREN.
  - Done when ramstate==ACCESS: dwait=0 combinationally that cycle, dload=ramload, next state IDLE.
- IGRANT:
  - ramaddr=iaddr, ramREN=1.
  - Done when ramstate==ACCESS: iwait=0, iload=ramload, next state IDLE.
- Completion pulse: the wait signal is low for exactly one cycle. A requester still asserting afterwards is re-arbitrated from IDLE, so back-to-back accesses cost at least 2 cycles each.
- Request withdrawal: if the granted request drops mid-grant, go to IDLE next cycle with no wait pulse and strobes low.
- Timeout and error:
  - tmo_cnt counts cycles in a grant state and clears in IDLE.
  - If ramstate==ERROR, or tmo_cnt reaches TIMEOUT-1 without ACCESS:
    - the requester's wait goes low for one cycle with load=BAD_WORD;
    - err is set;
    - next state IDLE.
  - ACCESS and timeout in the same cycle: ACCESS wins.
- Wait for the non-granted requester stays 1 throughout.
- iload/dload hold their last value when their wait is high.
- RAM strobes are 0 in IDLE.
- Reset asserted mid-grant: strobes drop immediately (asynchronous); no completion pulse is issued.

Decomposition:
- Shared package cache_mem_pkg:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR);
  - arb_state_t enum (IDLE/DGRANT/IGRANT);
  - word_t;
  - BAD_WORD constant.
- FSM, counters, and muxing stay in one module; no sub-module is needed.

Test Plan:
- Lone I read: iREN=1, iaddr=0x40; RAM gives ACCESS 2 cycles after ramREN with ramload=0x8C220000 -> iwait low for 1 cycle, iload=0x8C220000, dwait stays 1.
- Simultaneous I and D: iREN=1, dREN=1, daddr=0x100 -> D is granted first (ramaddr=0x100), I is served after dwait pulses; with D held continuously, I is granted after 4 D grants.
- Read/write collision: dREN=1, dWEN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dwait pulse on ACCESS.
- Timeout: D request with ramstate stuck BUSY -> at cycle 64 dwait pulses with dload=0xBAD1BAD1, err=1 and stays 1 until RST.
- Withdrawal and reset: iREN drops during IGRANT -> IDLE next cycle with no iwait pulse; RST asserted mid-DGRANT -> ramWEN=0 immediately, dwait=1, err=0.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
//   ramstate_t  : RAM status encoding seen on the ramstate input
//   arb_state_t : grant FSM states
//   word_t      : default memory word
//   BAD_WORD    : load value returned on RAM error or timeout
package cache_mem_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the caches, the arbiter and the RAM model.
//   Cache side : iREN/iaddr, dREN/dWEN/daddr/dstore requests;
//                iwait/iload, dwait/dload completions.
//   RAM side   : ramREN/ramWEN/ramaddr/ramstore strobes, ramload/ramstate.
//   err        : sticky error flag from the arbiter.
// Modports: slave = arbiter, master = caches + RAM (or a testbench).
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              iwait;
    logic              dwait;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates instruction- and data-cache requests onto one RAM port.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : cache_mem_arbiter_if.slave (requests, completions, RAM port, err)
// Data has priority; an instruction request that has watched ISTARVE
// consecutive data grants wins the next arbitration. Each grant ends on
// ACCESS, ERROR, timeout or withdrawal of the request, always via IDLE.
module cache_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 64,
    parameter int ISTARVE  = 4,
    parameter logic [DATA_W-1:0] BAD_WORD = cache_mem_pkg::BAD_WORD
) (
    input logic               CLK,
    input logic               RST,
    cache_mem_arbiter_if.slave bus
);
    import cache_mem_pkg::*;

    localparam int TMO_W  = $clog2(TIMEOUT) + 1;
    localparam int SCNT_W = $clog2(ISTARVE + 1) + 1;

    arb_state_t        state, state_nxt;
    logic [SCNT_W-1:0] starve_cnt, starve_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic              err_q, err_nxt;
    logic [DATA_W-1:0] iload_q, iload_nxt, dload_q, dload_nxt;
    logic              iwait_c, dwait_c, ramren_c, ramwen_c;
    logic [ADDR_W-1:0] ramaddr_c;
    logic [DATA_W-1:0] ramstore_c;
    ramstate_t         rs;
    logic              dreq, done_ok, done_bad, istarved;

    function automatic logic [SCNT_W-1:0] starve_inc(input logic [SCNT_W-1:0] c);
        return (c == SCNT_W'(ISTARVE)) ? c : c + 1'b1;
    endfunction

    assign rs       = ramstate_t'(bus.ramstate);
    assign dreq     = bus.dREN | bus.dWEN;
    assign done_ok  = (rs == ACCESS);
    // ACCESS outranks a timeout landing in the same cycle.
    assign done_bad = !done_ok && ((rs == ERROR) || (tmo_cnt == TMO_W'(TIMEOUT - 1)));
    assign istarved = bus.iREN && (starve_cnt == SCNT_W'(ISTARVE));

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        tmo_nxt    = '0;
        err_nxt    = err_q;
        iload_nxt  = iload_q;
        dload_nxt  = dload_q;
        iwait_c    = 1'b1;
        dwait_c    = 1'b1;
        ramren_c   = 1'b0;
        ramwen_c   = 1'b0;
        ramaddr_c  = '0;
        ramstore_c = '0;

        case (state)
            IDLE: begin
                if (dreq && !istarved) begin
                    state_nxt  = DGRANT;
                    starve_nxt = bus.iREN ? starve_inc(starve_cnt) : '0;
                end else if (bus.iREN) begin
                    state_nxt  = IGRANT;
                    starve_nxt = '0;
                end
            end
            DGRANT: begin
                ramaddr_c  = bus.daddr;
                ramstore_c = bus.dstore;
                ramwen_c   = bus.dWEN;
                ramren_c   = bus.dREN & ~bus.dWEN;
                if (!dreq) begin
                    state_nxt = IDLE;
                end else if (done_ok) begin
                    dwait_c   = 1'b0;
                    dload_nxt = bus.ramload;
                    state_nxt = IDLE;
                end else if (done_bad) begin
                    dwait_c   = 1'b0;
                    dload_nxt = BAD_WORD;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            IGRANT: begin
                ramaddr_c = bus.iaddr;
                // Follows iREN so a withdrawn request drops the strobe at once.
                ramren_c  = bus.iREN;
                if (!bus.iREN) begin
                    state_nxt = IDLE;
                end else if (done_ok) begin
                    iwait_c   = 1'b0;
                    iload_nxt = bus.ramload;
                    state_nxt = IDLE;
                end else if (done_bad) begin
                    iwait_c   = 1'b0;
                    iload_nxt = BAD_WORD;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!bus.iREN) begin
            starve_nxt = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tmo_cnt    <= tmo_nxt;
            err_q      <= err_nxt;
            iload_q    <= iload_nxt;
            dload_q    <= dload_nxt;
        end
    end

    // Load outputs show the completing word in the pulse cycle, else hold.
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = iload_nxt;
    assign bus.dload    = dload_nxt;
    assign bus.ramREN   = ramren_c;
    assign bus.ramWEN   = ramwen_c;
    assign bus.ramaddr  = ramaddr_c;
    assign bus.ramstore = ramstore_c;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios followed by a
// randomized request/latency/error phase checked against a
// transaction-level reference model.
module tb_cache_mem_arbiter;
    import cache_mem_pkg::*;

    localparam int ISTARVE = 4;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(64), .ISTARVE(ISTARVE),
        .BAD_WORD(32'hBAD1BAD1)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference-model state for the randomized phase.
    logic        ipend, dpend, gd, bad, err_exp;
    int          dmode, scount, lat;
    logic [31:0] ia, da, ds, gaddr, gload;

    initial begin
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;

        // Reset values
        #3;
        check("rst_iwait", bus.iwait, 1);
        check("rst_dwait", bus.dwait, 1);
        check("rst_iload", bus.iload, 0);
        check("rst_dload", bus.dload, 0);
        check("rst_ramREN", bus.ramREN, 0);
        check("rst_ramWEN", bus.ramWEN, 0);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_ramstore", bus.ramstore, 0);
        check("rst_err", bus.err, 0);
        step();
        step();
        rst = 0;

        // Lone instruction read, ACCESS two cycles after the strobe
        bus.iREN = 1; bus.iaddr = 32'h40;
        step();
        check("i_ramREN", bus.ramREN, 1);
        check("i_ramaddr", bus.ramaddr, 32'h40);
        bus.ramstate = BUSY;
        #1 check("i_busy_iwait", bus.iwait, 1);
        step();
        step();
        bus.ramstate = ACCESS; bus.ramload = 32'h8C220000;
        #1;
        check("i_pulse_iwait", bus.iwait, 0);
        check("i_pulse_iload", bus.iload, 32'h8C220000);
        check("i_pulse_dwait", bus.dwait, 1);
        step();
        bus.iREN = 0; bus.ramstate = FREE;
        #1;
        check("i_after_iwait", bus.iwait, 1);
        check("i_after_iload", bus.iload, 32'h8C220000);
        check("i_after_ramREN", bus.ramREN, 0);

        // Simultaneous I and D with D held: four D grants, then I
        bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h100;
        for (int g = 0; g < 5; g++) begin
            step();
            check("sim_ramaddr", bus.ramaddr, (g < 4) ? 32'h100 : 32'h80);
            bus.ramstate = ACCESS; bus.ramload = 32'h1000 + g;
            #1;
            check("sim_dwait", bus.dwait, (g < 4) ? 0 : 1);
            check("sim_iwait", bus.iwait, (g < 4) ? 1 : 0);
            if (g < 4) check("sim_dload", bus.dload, 32'h1000 + g);
            else       check("sim_iload", bus.iload, 32'h1004);
            step();
            bus.ramstate = FREE;
            if (g == 4) begin
                bus.iREN = 0; bus.dREN = 0;
            end
        end

        // Read/write collision: write wins
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
        step();
        check("col_ramWEN", bus.ramWEN, 1);
        check("col_ramREN", bus.ramREN, 0);
        check("col_ramstore", bus.ramstore, 32'hDEADBEEF);
        bus.ramstate = ACCESS;
        #1 check("col_dwait", bus.dwait, 0);
        step();
        bus.dREN = 0; bus.dWEN = 0; bus.ramstate = FREE;

        // Randomized phase: requests held until served, random latency/errors
        ipend = 0; dpend = 0; scount = 0; err_exp = 0;
        dmode = 0; ia = 0; da = 0; ds = 0;
        for (int r = 0; r < 60; r++) begin
            if (!ipend && $urandom_range(0, 1) == 1) begin
                ipend = 1; ia = $urandom & 32'h0000_FFFC;
            end
            if (!dpend && $urandom_range(0, 1) == 1) begin
                dpend = 1; dmode = $urandom_range(0, 2);
                da = $urandom & 32'h0000_FFFC; ds = $urandom;
            end
            if (!ipend && !dpend) begin
                ipend = 1; ia = $urandom & 32'h0000_FFFC;
            end
            bus.iREN = ipend; bus.iaddr = ia;
            bus.dREN = dpend && (dmode != 1); bus.dWEN = dpend && (dmode != 0);
            bus.daddr = da; bus.dstore = ds; bus.ramstate = FREE;

            // Data first unless I has sat through ISTARVE data grants
            gd = dpend && !(ipend && scount == ISTARVE);
            if (gd) scount = ipend ? ((scount < ISTARVE) ? scount + 1 : ISTARVE) : 0;
            else    scount = 0;
            gaddr = gd ? da : ia;
            lat = $urandom_range(0, 3);
            bad = ($urandom_range(0, 9) == 0);
            gload = bad ? 32'hBAD1BAD1 : (gaddr ^ KEY);

            step();
            check("rnd_ramaddr", bus.ramaddr, gaddr);
            check("rnd_ramWEN", bus.ramWEN, gd && dmode != 0);
            check("rnd_ramREN", bus.ramREN, gd ? (dmode == 0) : 1'b1);
            if (gd && dmode != 0) check("rnd_ramstore", bus.ramstore, ds);
            for (int k = 0; k <= lat; k++) begin
                if (k > 0) step();
                bus.ramstate = (k == lat) ? (bad ? ERROR : ACCESS) : BUSY;
                bus.ramload = bus.ramaddr ^ KEY;
                #1;
                if (k < lat) check("rnd_wait_busy", {bus.iwait, bus.dwait}, 2'b11);
            end
            if (gd) begin
                check("rnd_dwait", bus.dwait, 0);
                check("rnd_dload", bus.dload, gload);
                check("rnd_iwait_idle", bus.iwait, 1);
            end else begin
                check("rnd_iwait", bus.iwait, 0);
                check("rnd_iload", bus.iload, gload);
                check("rnd_dwait_idle", bus.dwait, 1);
            end
            if (bad) err_exp = 1;
            step();
            if (gd) dpend = 0; else ipend = 0;
            bus.iREN = ipend; bus.dREN = dpend && (dmode != 1); bus.dWEN = dpend && (dmode != 0);
            bus.ramstate = FREE;
            #1 check("rnd_err", bus.err, err_exp);
        end
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        step();

        // Timeout with RAM stuck BUSY
        bus.dREN = 1; bus.daddr = 32'h300;
        step();
        bus.ramstate = BUSY;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) step();
            #1;
            if (k == 63) begin
                check("tmo_dwait", bus.dwait, 0);
                check("tmo_dload", bus.dload, 32'hBAD1BAD1);
            end else if (k == 0 || k == 62) begin
                check("tmo_dwait_early", bus.dwait, 1);
            end
        end
        step();
        bus.dREN = 0; bus.ramstate = FREE;
        #1;
        check("tmo_err", bus.err, 1);
        check("tmo_dload_hold", bus.dload, 32'hBAD1BAD1);
        step();
        step();
        check("tmo_err_sticky", bus.err, 1);

        // Withdrawal of an instruction request mid-grant
        bus.iREN = 1; bus.iaddr = 32'h44;
        step();
        bus.ramstate = BUSY;
        #1 check("wd_ramREN", bus.ramREN, 1);
        step();
        bus.iREN = 0;
        #1;
        check("wd_ramREN_drop", bus.ramREN, 0);
        check("wd_iwait", bus.iwait, 1);
        step();
        bus.ramstate = ACCESS;
        #1;
        check("wd_idle_iwait", bus.iwait, 1);
        check("wd_idle_ramaddr", bus.ramaddr, 0);
        bus.ramstate = FREE;

        // Reset asserted mid data grant
        bus.dWEN = 1; bus.daddr = 32'h400; bus.dstore = 32'h1234;
        step();
        #1 check("rg_ramWEN", bus.ramWEN, 1);
        bus.ramstate = ACCESS;
        #1 rst = 1;
        #1;
        check("rg_ramWEN_drop", bus.ramWEN, 0);
        check("rg_dwait", bus.dwait, 1);
        check("rg_err", bus.err, 0);
        check("rg_dload", bus.dload, 0);
        bus.dWEN = 0; bus.ramstate = FREE;
        step();
        rst = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
